// File: rtl/div_prog_tick_gen.sv
// div_prog_tick_gen
// Programmable clock-enable generator for slow serial engines (I2C SCL/SDA
// sequencing). Emits a single-cycle tick once per period plus a wrapping
// phase count. The division ratio can be loaded at runtime, and a loaded
// value only takes effect at a period boundary (or immediately while idle),
// so no truncated or stretched period is ever produced.
//
// Optional build macro: DIV_PROG_TMR_EN
//   When defined, the counter, phase, active/pending division and pending
//   flag are held in three copies. Each copy is updated from the bitwise
//   majority vote, and tmr_err pulses for one cycle whenever a copy
//   disagrees with the vote. When undefined, single registers are used and
//   tmr_err is tied low.
module div_prog_tick_gen #(
    parameter int CNT_W   = 10,
    parameter int DEF_DIV = 100,
    parameter int PH_W    = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [CNT_W-1:0] div_val,
    input  logic             div_load,
    output logic [CNT_W-1:0] div_cur,
    output logic             div_pend,
    output logic             div_ack,
    output logic             tick,
    output logic [PH_W-1:0]  phase,
    output logic             tmr_err
);

    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEF_DIV);
    localparam logic [CNT_W-1:0] DIV_MIN = CNT_W'(2);

    // Current (voted, when triplicated) view of the state registers.
    logic [CNT_W-1:0] cnt_v;
    logic [CNT_W-1:0] div_cur_v;
    logic [CNT_W-1:0] pend_v;
    logic [PH_W-1:0]  phase_v;
    logic             div_pend_v;

    // Next-state values shared by all copies.
    logic [CNT_W-1:0] cnt_n;
    logic [CNT_W-1:0] div_cur_n;
    logic [CNT_W-1:0] pend_n;
    logic [PH_W-1:0]  phase_n;
    logic             div_pend_n;
    logic [CNT_W-1:0] load_val;
    logic             boundary;
    logic             apply;

    // Next-state logic: count, detect the period boundary, and decide when a
    // pending division value is promoted to the active one.
    always_comb begin
        load_val = (div_val < DIV_MIN) ? DIV_MIN : div_val;
        boundary = en && (cnt_v == div_cur_v - CNT_W'(1));
        apply    = div_pend_v && (boundary || !en);

        if (!en) begin
            cnt_n   = '0;
            phase_n = '0;
        end else if (boundary) begin
            cnt_n   = '0;
            phase_n = phase_v + PH_W'(1);
        end else begin
            cnt_n   = cnt_v + CNT_W'(1);
            phase_n = phase_v;
        end

        div_cur_n  = apply ? pend_v : div_cur_v;
        pend_n     = div_load ? load_val : pend_v;
        div_pend_n = div_load || (div_pend_v && !apply);
    end

    // Single-cycle tick and acknowledge pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick    <= 1'b0;
            div_ack <= 1'b0;
        end else begin
            tick    <= boundary;
            div_ack <= apply;
        end
    end

`ifdef DIV_PROG_TMR_EN
    logic [CNT_W-1:0] cnt_q     [3];
    logic [CNT_W-1:0] div_cur_q [3];
    logic [CNT_W-1:0] pend_q    [3];
    logic [PH_W-1:0]  phase_q   [3];
    logic             div_pend_q[3];
    logic             mismatch;

    assign cnt_v      = (cnt_q[0] & cnt_q[1]) | (cnt_q[0] & cnt_q[2]) | (cnt_q[1] & cnt_q[2]);
    assign div_cur_v  = (div_cur_q[0] & div_cur_q[1]) | (div_cur_q[0] & div_cur_q[2]) |
                        (div_cur_q[1] & div_cur_q[2]);
    assign pend_v     = (pend_q[0] & pend_q[1]) | (pend_q[0] & pend_q[2]) | (pend_q[1] & pend_q[2]);
    assign phase_v    = (phase_q[0] & phase_q[1]) | (phase_q[0] & phase_q[2]) |
                        (phase_q[1] & phase_q[2]);
    assign div_pend_v = (div_pend_q[0] & div_pend_q[1]) | (div_pend_q[0] & div_pend_q[2]) |
                        (div_pend_q[1] & div_pend_q[2]);

    // Flag any copy that disagrees with the majority vote.
    always_comb begin
        mismatch = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (cnt_q[i] != cnt_v || div_cur_q[i] != div_cur_v || pend_q[i] != pend_v ||
                phase_q[i] != phase_v || div_pend_q[i] != div_pend_v) begin
                mismatch = 1'b1;
            end
        end
    end

    // All three copies reload from the voted next state, scrubbing upsets.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                cnt_q[i]      <= '0;
                div_cur_q[i]  <= DIV_RST;
                pend_q[i]     <= '0;
                phase_q[i]    <= '0;
                div_pend_q[i] <= 1'b0;
            end
            tmr_err <= 1'b0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                cnt_q[i]      <= cnt_n;
                div_cur_q[i]  <= div_cur_n;
                pend_q[i]     <= pend_n;
                phase_q[i]    <= phase_n;
                div_pend_q[i] <= div_pend_n;
            end
            tmr_err <= mismatch;
        end
    end
`else
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] div_cur_q;
    logic [CNT_W-1:0] pend_q;
    logic [PH_W-1:0]  phase_q;
    logic             div_pend_q;

    assign cnt_v      = cnt_q;
    assign div_cur_v  = div_cur_q;
    assign pend_v     = pend_q;
    assign phase_v    = phase_q;
    assign div_pend_v = div_pend_q;
    assign tmr_err    = 1'b0;

    // Plain state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q      <= '0;
            div_cur_q  <= DIV_RST;
            pend_q     <= '0;
            phase_q    <= '0;
            div_pend_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_n;
            div_cur_q  <= div_cur_n;
            pend_q     <= pend_n;
            phase_q    <= phase_n;
            div_pend_q <= div_pend_n;
        end
    end
`endif

    assign div_cur  = div_cur_v;
    assign div_pend = div_pend_v;
    assign phase    = phase_v;

endmodule

// File: tb/tb_div_prog_tick_gen.sv
// Testbench for div_prog_tick_gen (default build).
// A reference model tracks the period as a countdown of remaining cycles and
// applies the load/apply rules directly; DUT outputs are compared with it
// every cycle, plus a constant vector table and hand-written corner cases.
module tb_div_prog_tick_gen;

    localparam int CNT_W   = 10;
    localparam int PH_W    = 2;
    localparam int DEF_DIV = 100;

    logic             clk      = 1'b0;
    logic             reset    = 1'b1;
    logic             en       = 1'b0;
    logic             div_load = 1'b0;
    logic [CNT_W-1:0] div_val  = '0;
    logic [CNT_W-1:0] div_cur;
    logic             div_pend;
    logic             div_ack;
    logic             tick;
    logic [PH_W-1:0]  phase;
    logic             tmr_err;

    int tests = 0;
    int fails = 0;

    // Reference model state.
    int mCur;
    int mLeft;
    int mPhase;
    int mPendVal;
    bit mPend;
    bit mTick;
    bit mAck;

    typedef struct {
        bit e;
        bit l;
        int v;
        bit xTick;
        bit xAck;
        bit xPend;
        int xCur;
        int xPhase;
    } vec_t;

    vec_t tbl[15];

    always #5 clk = ~clk;

    div_prog_tick_gen #(
        .CNT_W  (CNT_W),
        .DEF_DIV(DEF_DIV),
        .PH_W   (PH_W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .div_val (div_val),
        .div_load(div_load),
        .div_cur (div_cur),
        .div_pend(div_pend),
        .div_ack (div_ack),
        .tick    (tick),
        .phase   (phase),
        .tmr_err (tmr_err)
    );

    task automatic modelReset();
        mCur     = DEF_DIV;
        mLeft    = 0;
        mPhase   = 0;
        mPendVal = 0;
        mPend    = 1'b0;
        mTick    = 1'b0;
        mAck     = 1'b0;
    endtask

    // mLeft == 0 means no period is in progress; a new one starts at the
    // next enabled edge with the then-active division.
    task automatic modelStep(input bit e, input bit l, input int v);
        int len;
        bit bnd;
        bit app;
        len = (mLeft == 0) ? mCur : mLeft;
        bnd = e && (len == 1);
        app = mPend && (!e || bnd);
        mTick = bnd;
        mAck  = app;
        if (!e) begin
            mLeft  = 0;
            mPhase = 0;
        end else if (bnd) begin
            mLeft  = 0;
            mPhase = (mPhase + 1) % (1 << PH_W);
        end else begin
            mLeft = len - 1;
        end
        if (app) begin
            mCur  = mPendVal;
            mPend = 1'b0;
        end
        if (l) begin
            mPendVal = (v < 2) ? 2 : v;
            mPend    = 1'b1;
        end
    endtask

    task automatic checkOutput(input string name);
        tests++;
        if (tick !== mTick || div_ack !== mAck || div_pend !== mPend ||
            div_cur !== CNT_W'(mCur) || phase !== PH_W'(mPhase) || tmr_err !== 1'b0) begin
            fails++;
            $display("[TB] FAIL %s @%0t: got tick=%b ack=%b pend=%b cur=%0d phase=%0d err=%b, want tick=%b ack=%b pend=%b cur=%0d phase=%0d err=0",
                     name, $time, tick, div_ack, div_pend, div_cur, phase, tmr_err,
                     mTick, mAck, mPend, mCur, mPhase);
        end
    endtask

    task automatic checkVal(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            fails++;
            $display("[TB] FAIL %s @%0t: got %0d, want %0d", name, $time, actual, expected);
        end
    endtask

    // Drive one set of inputs across one rising edge and compare with the model.
    task automatic applyStimulus(input string name, input bit e, input bit l, input int v);
        en       = e;
        div_load = l;
        div_val  = CNT_W'(v);
        @(posedge clk);
        modelStep(e, l, v);
        #1;
        checkOutput(name);
    endtask

    // Assert reset between edges, check the asynchronous response, release.
    task automatic resetDut();
        en       = 1'b0;
        div_load = 1'b0;
        div_val  = '0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        modelReset();
        #2;
        checkOutput("resetValues");
        @(posedge clk);
        #3;
        reset = 1'b0;
    endtask

    initial begin
        int ackCount;
        int tickCount;

        // e, l, v | tick, ack, pend, cur, phase
        tbl[0]  = '{0, 1, 0, 0, 0, 1, 100, 0};
        tbl[1]  = '{0, 0, 0, 0, 1, 0, 2, 0};
        tbl[2]  = '{1, 0, 0, 0, 0, 0, 2, 0};
        tbl[3]  = '{1, 0, 0, 1, 0, 0, 2, 1};
        tbl[4]  = '{1, 1, 1, 0, 0, 1, 2, 1};
        tbl[5]  = '{1, 0, 0, 1, 1, 0, 2, 2};
        tbl[6]  = '{1, 0, 0, 0, 0, 0, 2, 2};
        tbl[7]  = '{1, 0, 0, 1, 0, 0, 2, 3};
        tbl[8]  = '{1, 1, 5, 0, 0, 1, 2, 3};
        tbl[9]  = '{1, 0, 0, 1, 1, 0, 5, 0};
        tbl[10] = '{1, 0, 0, 0, 0, 0, 5, 0};
        tbl[11] = '{1, 0, 0, 0, 0, 0, 5, 0};
        tbl[12] = '{1, 0, 0, 0, 0, 0, 5, 0};
        tbl[13] = '{1, 0, 0, 0, 0, 0, 5, 0};
        tbl[14] = '{1, 0, 0, 1, 0, 0, 5, 1};

        modelReset();

        // Default period: first tick on the 100th enabled edge, phase wraps.
        resetDut();
        for (int i = 1; i <= 450; i++) begin
            applyStimulus("defaultRun", 1'b1, 1'b0, 0);
            if (i == 99)  checkVal("noTickAt99", int'(tick), 0);
            if (i == 100) checkVal("firstTickAt100", int'(tick), 1);
            if (i == 100) checkVal("phaseAfterFirst", int'(phase), 1);
            if (i == 400) checkVal("phaseWrapAt400", int'(phase), 0);
        end

        // Load 10 at cnt=40: the running period still ends at 100.
        resetDut();
        for (int i = 1; i <= 130; i++) begin
            applyStimulus("load10", 1'b1, i == 41, 10);
            if (i == 41)  checkVal("pendAfterLoad", int'(div_pend), 1);
            if (i == 100) checkVal("ackAtBoundary", int'(div_ack), 1);
            if (i == 100) checkVal("curBecomes10", int'(div_cur), 10);
            if (i == 110) checkVal("tickAt110", int'(tick), 1);
        end

        // Clamp and phase stepping, constant vector table.
        resetDut();
        for (int r = 0; r < 15; r++) begin
            applyStimulus("tableModel", tbl[r].e, tbl[r].l, tbl[r].v);
            tests++;
            if (tick !== tbl[r].xTick || div_ack !== tbl[r].xAck || div_pend !== tbl[r].xPend ||
                div_cur !== CNT_W'(tbl[r].xCur) || phase !== PH_W'(tbl[r].xPhase)) begin
                fails++;
                $display("[TB] FAIL tableRow%0d: got tick=%b ack=%b pend=%b cur=%0d phase=%0d, want tick=%b ack=%b pend=%b cur=%0d phase=%0d",
                         r, tick, div_ack, div_pend, div_cur, phase,
                         tbl[r].xTick, tbl[r].xAck, tbl[r].xPend, tbl[r].xCur, tbl[r].xPhase);
            end
        end

        // Two loads in one period: only the last one applies, once.
        resetDut();
        ackCount = 0;
        for (int i = 1; i <= 160; i++) begin
            if (i == 20)      applyStimulus("twoLoads", 1'b1, 1'b1, 25);
            else if (i == 60) applyStimulus("twoLoads", 1'b1, 1'b1, 50);
            else              applyStimulus("twoLoads", 1'b1, 1'b0, 0);
            ackCount += int'(div_ack);
            if (i == 100) checkVal("curBecomes50", int'(div_cur), 50);
            if (i == 125) checkVal("noTickAt125", int'(tick), 0);
            if (i == 150) checkVal("tickAt150", int'(tick), 1);
        end
        checkVal("singleAck", ackCount, 1);

        // Load 7 on the boundary edge while 20 is pending.
        resetDut();
        applyStimulus("idleLoad30", 1'b0, 1'b1, 30);
        applyStimulus("idleApply30", 1'b0, 1'b0, 0);
        checkVal("idleAck", int'(div_ack), 1);
        for (int i = 1; i <= 80; i++) begin
            if (i == 6)       applyStimulus("boundaryLoad", 1'b1, 1'b1, 20);
            else if (i == 30) applyStimulus("boundaryLoad", 1'b1, 1'b1, 7);
            else              applyStimulus("boundaryLoad", 1'b1, 1'b0, 0);
            if (i == 30) checkVal("apply20Ack", int'(div_ack), 1);
            if (i == 30) checkVal("cur20", int'(div_cur), 20);
            if (i == 30) checkVal("pend7Still", int'(div_pend), 1);
            if (i == 50) checkVal("apply7Ack", int'(div_ack), 1);
            if (i == 50) checkVal("cur7", int'(div_cur), 7);
            if (i == 57) checkVal("tickAt57", int'(tick), 1);
        end

        // Drop en mid-period after one tick; restart takes a full period.
        resetDut();
        for (int i = 1; i <= 130; i++) applyStimulus("preDrop", 1'b1, 1'b0, 0);
        checkVal("phaseBeforeDrop", int'(phase), 1);
        for (int i = 1; i <= 5; i++) applyStimulus("enLow", 1'b0, 1'b0, 0);
        checkVal("phaseClearedIdle", int'(phase), 0);
        tickCount = 0;
        for (int i = 1; i <= 100; i++) begin
            applyStimulus("reEnable", 1'b1, 1'b0, 0);
            if (i < 100) tickCount += int'(tick);
            if (i == 100) checkVal("tickFullPeriodAfterReenable", int'(tick), 1);
        end
        checkVal("noEarlyTick", tickCount, 0);

        // Randomized traffic with occasional mid-run resets.
        resetDut();
        for (int i = 1; i <= 3000; i++) begin
            bit e;
            bit l;
            int v;
            e = ($urandom_range(0, 19) != 0);
            l = ($urandom_range(0, 15) == 0);
            v = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 40)) : int'($urandom_range(0, 6));
            applyStimulus("random", e, l, v);
            if (i % 700 == 0) resetDut();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
